// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP datapath blocks
// (fp_to_fixed and the future FP adder).
package fp_pkg;

   localparam int FP_EXP_BIAS    = 127;
   localparam int FP_EXP_SPECIAL = 255;
   localparam int FP_MANT_W      = 23;

   // Conversion FSM state encoding
   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_SHIFT = 3'd1,
      S_ROUND = 3'd2,
      S_SIGN  = 3'd3,
      S_DONE  = 3'd4
   } fsm_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single-precision field split with class flags.
// The hidden leading one is always inserted; callers flush denormals.
module fp_unpack
   import fp_pkg::*;
(
   input  logic [31:0] fp_in,
   output logic        sign,
   output logic [7:0]  exp,
   output logic [23:0] mant,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan
);

   logic frac_nz;

   // Field split and classification
   always_comb begin
      sign    = fp_in[31];
      exp     = fp_in[30:23];
      mant    = {1'b1, fp_in[FP_MANT_W-1:0]};
      frac_nz = |fp_in[FP_MANT_W-1:0];
      is_zero = (exp == 8'd0);
      is_inf  = (exp == 8'(FP_EXP_SPECIAL)) && !frac_nz;
      is_nan  = (exp == 8'(FP_EXP_SPECIAL)) && frac_nz;
   end

endmodule

// File: rtl/fp_to_fixed.sv
// IEEE-754 single to signed fixed-point sample converter (Q1.15 default).
// Serial right shifter: a conversion starts when reset drops, done is sticky
// until the next reset.
// Build option: FP2FIX_ROUND_NEAREST_EN selects round-half-away-from-zero;
// without it the result truncates toward zero. Latency is the same either way.
module fp_to_fixed
   import fp_pkg::*;
#(
   parameter int OUT_WIDTH = 16,
   parameter int FRAC_BITS = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          dataa,
   output logic [OUT_WIDTH-1:0] result,
   output logic                 done
);

   // Exponent at or above which the magnitude no longer fits
   localparam int SAT_E  = FP_EXP_BIAS + OUT_WIDTH - 1 - FRAC_BITS;
   // Right shift is R_BASE - e
   localparam int R_BASE = FP_EXP_BIAS + FP_MANT_W - FRAC_BITS;

   localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] NEG_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [23:0]          SAT_MAG = 24'(1) << (OUT_WIDTH - 1);

   logic        in_sign;
   logic [7:0]  in_exp;
   logic [23:0] in_mant;
   logic        in_zero, in_inf, in_nan;

   fp_unpack u_unpack (
      .fp_in   (dataa),
      .sign    (in_sign),
      .exp     (in_exp),
      .mant    (in_mant),
      .is_zero (in_zero),
      .is_inf  (in_inf),
      .is_nan  (in_nan)
   );

   fsm_state_t           state_q, state_d;
   logic [23:0]          mag_q, mag_d;
   logic [4:0]           cnt_q, cnt_d;
   logic                 guard_q, guard_d;
   logic                 sat_q, sat_d;
   logic                 sign_q, sign_d;
   logic [OUT_WIDTH-1:0] result_q, result_d;
   logic                 done_q, done_d;

   logic [9:0]           shift_r;
   logic [OUT_WIDTH:0]   mag_ext, neg_ext;

   // Shift amount is only meaningful once the saturating exponents are excluded
   assign shift_r = 10'(R_BASE) - {2'b00, in_exp};
   // Negation is carried one bit wider than the output
   assign mag_ext = {1'b0, mag_q[OUT_WIDTH-1:0]};
   assign neg_ext = ~mag_ext + (OUT_WIDTH+1)'(1);

   // Next-state and datapath for the conversion sequence
   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      guard_d  = guard_q;
      sat_d    = sat_q;
      sign_d   = sign_q;
      result_d = result_q;
      done_d   = done_q;
      case (state_q)
         S_LOAD: begin
            sign_d = in_sign;
            if (in_zero || in_nan) begin
               result_d = '0;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else if (in_inf || ({2'b00, in_exp} >= 10'(SAT_E))) begin
               result_d = in_sign ? NEG_MIN : POS_MAX;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else if (shift_r >= 10'd25) begin
               // Everything shifts out and not even rounding reaches one LSB
               result_d = '0;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end else begin
               mag_d   = in_mant;
               cnt_d   = shift_r[4:0];
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            mag_d   = mag_q >> 1;
            guard_d = mag_q[0];
            cnt_d   = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = S_ROUND;
         end
         S_ROUND: begin
`ifdef FP2FIX_ROUND_NEAREST_EN
            mag_d = mag_q + {23'd0, guard_q};
`else
            mag_d = mag_q;
`endif
            sat_d   = (mag_d >= SAT_MAG);
            state_d = S_SIGN;
         end
         S_SIGN: begin
            if (sat_q)       result_d = sign_q ? NEG_MIN : POS_MAX;
            else if (sign_q) result_d = neg_ext[OUT_WIDTH-1:0];
            else             result_d = mag_ext[OUT_WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: ;
         default: state_d = S_LOAD;
      endcase
   end

   // State registers; reset aborts any conversion in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_LOAD;
         mag_q    <= '0;
         cnt_q    <= '0;
         guard_q  <= 1'b0;
         sat_q    <= 1'b0;
         sign_q   <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         guard_q  <= guard_d;
         sat_q    <= sat_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_fp_to_fixed.sv
// Directed bench for fp_to_fixed at default parameters (Q1.15).
module tb_fp_to_fixed;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dataa = 32'd0;
   logic [15:0] result;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp_to_fixed dut (
      .clk    (clk),
      .reset  (reset),
      .dataa  (dataa),
      .result (result),
      .done   (done)
   );

   // Pulse reset, release with d, count edges from edge 1 for a fixed window.
   // dataa is corrupted after edge 1 to show it is sampled only once.
   task automatic run_conv(input logic [31:0] d, output int done_edge,
                           output logic [15:0] res, output bit held);
      @(negedge clk); reset = 1'b1; dataa = ~d;
      @(negedge clk); reset = 1'b0; dataa = d;
      done_edge = -1; res = 16'hxxxx; held = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         if (k == 1) dataa = ~d;
         if (done && done_edge < 0) begin
            done_edge = k; res = result;
         end else if (done_edge >= 0 && (done !== 1'b1 || result !== res)) begin
            held = 1'b0;
         end
      end
      if (done_edge < 0) res = result;
   endtask

   task automatic test_reset();
      @(negedge clk); reset = 1'b1; dataa = 32'h3F800000;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done cyc%0d got %b want 0", k, done); end
         n_cmp++;
         if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result cyc%0d got %h want 0000", k, result); end
      end
   endtask

   task automatic test_normal();
      logic [31:0] din [3] = '{32'h3F000000, 32'hBE800000, 32'h38C00000};
      logic [15:0] exp [3] = '{16'h4000, 16'hE000, 16'h0003};
      int          edg [3] = '{12, 13, 25};
      int de; logic [15:0] r; bit h;
      for (int i = 0; i < 3; i++) begin
         run_conv(din[i], de, r, h);
         n_cmp++;
         if (de !== edg[i]) begin n_bad++; $display("FAIL normal_latency %h got edge %0d want %0d", din[i], de, edg[i]); end
         n_cmp++;
         if (r !== exp[i]) begin n_bad++; $display("FAIL normal_result %h got %h want %h", din[i], r, exp[i]); end
         n_cmp++;
         if (h !== 1'b1) begin n_bad++; $display("FAIL normal_hold %h done/result not held", din[i]); end
      end
   endtask

   task automatic test_special();
      logic [31:0] din [9] = '{32'h3F800000, 32'hBF800000, 32'h7F800000, 32'hFF800000,
                               32'h7FC00000, 32'hFFC00001, 32'h00000001, 32'h47000000,
                               32'h37000000};
      logic [15:0] exp [9] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                               16'h0000, 16'h0000, 16'h0000, 16'h7FFF,
                               16'h0000};
      int de; logic [15:0] r; bit h;
      for (int i = 0; i < 9; i++) begin
         run_conv(din[i], de, r, h);
         n_cmp++;
         if (de !== 1) begin n_bad++; $display("FAIL special_latency %h got edge %0d want 1", din[i], de); end
         n_cmp++;
         if (r !== exp[i]) begin n_bad++; $display("FAIL special_result %h got %h want %h", din[i], r, exp[i]); end
         n_cmp++;
         if (h !== 1'b1) begin n_bad++; $display("FAIL special_hold %h done/result not held", din[i]); end
      end
   endtask

   task automatic test_round();
      logic [31:0] din [5] = '{32'h37800000, 32'h38400000, 32'hB8400000,
                               32'h3F7FFFFF, 32'hBF7FFFFF};
`ifdef FP2FIX_ROUND_NEAREST_EN
      logic [15:0] exp [5] = '{16'h0001, 16'h0002, 16'hFFFE, 16'h7FFF, 16'h8000};
`else
      logic [15:0] exp [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8001};
`endif
      int          edg [5] = '{27, 26, 26, 12, 12};
      int de; logic [15:0] r; bit h;
      for (int i = 0; i < 5; i++) begin
         run_conv(din[i], de, r, h);
         n_cmp++;
         if (de !== edg[i]) begin n_bad++; $display("FAIL round_latency %h got edge %0d want %0d", din[i], de, edg[i]); end
         n_cmp++;
         if (r !== exp[i]) begin n_bad++; $display("FAIL round_result %h got %h want %h", din[i], r, exp[i]); end
      end
   endtask

   task automatic test_abort();
      int de; logic [15:0] r; bit h;
      // Abort mid-conversion at edge 5
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; dataa = 32'h3F000000;
      for (int k = 1; k <= 4; k++) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
      n_cmp++;
      if (result !== 16'h0000) begin n_bad++; $display("FAIL abort_result got %h want 0000", result); end
      // Restart cleanly after the abort
      run_conv(32'hBE800000, de, r, h);
      n_cmp++;
      if (de !== 13) begin n_bad++; $display("FAIL restart_latency got edge %0d want 13", de); end
      n_cmp++;
      if (r !== 16'hE000) begin n_bad++; $display("FAIL restart_result got %h want e000", r); end
      // Reset after completion clears the sticky outputs
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL post_done_reset_done got %b want 0", done); end
      n_cmp++;
      if (result !== 16'h0000) begin n_bad++; $display("FAIL post_done_reset_result got %h want 0000", result); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_special();
      test_round();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
